// File: rtl/regbank_mp_if.sv
// Register bank bus: write ports A/B, three read ports, clear request, READY.
// master drives addresses/data/enables; slave returns read data and READY.
interface regbank_mp_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic          CLR_REQ;
  logic          WE_A;
  logic [AW-1:0] WA_A;
  logic [DW-1:0] WD_A;
  logic          WE_B;
  logic [AW-1:0] WA_B;
  logic [DW-1:0] WD_B;
  logic [AW-1:0] RA_0;
  logic [AW-1:0] RA_1;
  logic [AW-1:0] RA_2;
  logic [DW-1:0] RD_0;
  logic [DW-1:0] RD_1;
  logic [DW-1:0] RD_2;
  logic          READY;

  modport master (
    output CLR_REQ, WE_A, WA_A, WD_A,
    output WE_B, WA_B, WD_B,
    output RA_0, RA_1, RA_2,
    input  RD_0, RD_1, RD_2, READY
  );

  modport slave (
    input  CLR_REQ, WE_A, WA_A, WD_A,
    input  WE_B, WA_B, WD_B,
    input  RA_0, RA_1, RA_2,
    output RD_0, RD_1, RD_2, READY
  );
endinterface

// File: rtl/regbank_mp.sv
// Multi-port register bank: 3 async reads, 2 sync writes (B beats A),
// optional bypass and zero register, hardware clear sequencer.
// Ports: CLK, RST (sync active-high), bus (regbank_mp_if.slave).
module regbank_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic         CLK,
  input logic         RST,
  regbank_mp_if.slave bus
);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          run;
  logic          wr_en;
  logic [AW-1:0] ra   [3];
  logic [DW-1:0] rd   [3];

  assign run   = (state_q == S_RUN);
  assign wr_en = run && !bus.CLR_REQ;

  // Address is a real, writable entry.
  function automatic logic wr_ok(
    input logic [AW-1:0] a
  );
    logic ok;
    ok = ({1'b0, a} < (AW+1)'(DEPTH));
    if (ZERO_REG != 0 && a == '0)
      ok = 1'b0;
    return ok;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    mem_d   = mem_q;
    if (RST) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          for (int i = 0; i < DEPTH; i++)
            if (cnt_q == AW'(i))
              mem_d[i] = '0;
          cnt_d = cnt_q + 1'b1;
          // Compare to DEPTH-1 so non-pow2 depths stop on time.
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = S_RUN;
            ready_d = 1'b1;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          if (bus.CLR_REQ) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
          end else begin
            // B applied last so it wins an address collision.
            for (int i = 0; i < DEPTH; i++) begin
              if (ZERO_REG == 0 || i != 0) begin
                if (bus.WE_A && bus.WA_A == AW'(i))
                  mem_d[i] = bus.WD_A;
                if (bus.WE_B && bus.WA_B == AW'(i))
                  mem_d[i] = bus.WD_B;
              end
            end
          end
        end
        default: begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign ra[0] = bus.RA_0;
  assign ra[1] = bus.RA_1;
  assign ra[2] = bus.RA_2;

  // A matching in-range read address implies the write is not dropped
  // by range/zero rules; only CLR_REQ needs an explicit guard.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd[p] = '0;
      if (run && wr_ok(ra[p])) begin
        for (int i = 0; i < DEPTH; i++)
          if (ra[p] == AW'(i))
            rd[p] = mem_q[i];
        if (BYPASS != 0 && wr_en) begin
          if (bus.WE_B && bus.WA_B == ra[p])
            rd[p] = bus.WD_B;
          else if (bus.WE_A && bus.WA_A == ra[p])
            rd[p] = bus.WD_A;
        end
      end
    end
  end

  assign bus.RD_0  = rd[0];
  assign bus.RD_1  = rd[1];
  assign bus.RD_2  = rd[2];
  assign bus.READY = ready_q;

endmodule

// File: tb/tb_regbank_mp.sv
// Bench for regbank_mp: u0 default config, u1 DEPTH=40/ZERO_REG/no bypass.
// Both instances get identical stimulus; each has its own expectations.
module tb_regbank_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regbank_mp_if #(.DW(32), .AW(6)) b0 ();
  regbank_mp_if #(.DW(32), .AW(6)) b1 ();

  regbank_mp #(
    .DW(32), .DEPTH(64), .AW(6), .ZERO_REG(0), .BYPASS(1)
  ) u0 (
    .CLK(clk), .RST(rst), .bus(b0)
  );

  regbank_mp #(
    .DW(32), .DEPTH(40), .AW(6), .ZERO_REG(1), .BYPASS(0)
  ) u1 (
    .CLK(clk), .RST(rst), .bus(b1)
  );

  typedef struct {
    logic        we_a;
    logic [5:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_b;
    logic [5:0]  wa_b;
    logic [31:0] wd_b;
    logic [5:0]  ra0;
    logic [5:0]  ra1;
    logic [5:0]  ra2;
    logic [31:0] e00;
    logic [31:0] e01;
    logic [31:0] e02;
    logic [31:0] e10;
    logic [31:0] e11;
    logic [31:0] e12;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    b0.WE_A = v.we_a; b1.WE_A = v.we_a;
    b0.WA_A = v.wa_a; b1.WA_A = v.wa_a;
    b0.WD_A = v.wd_a; b1.WD_A = v.wd_a;
    b0.WE_B = v.we_b; b1.WE_B = v.we_b;
    b0.WA_B = v.wa_b; b1.WA_B = v.wa_b;
    b0.WD_B = v.wd_b; b1.WD_B = v.wd_b;
    b0.RA_0 = v.ra0;  b1.RA_0 = v.ra0;
    b0.RA_1 = v.ra1;  b1.RA_1 = v.ra1;
    b0.RA_2 = v.ra2;  b1.RA_2 = v.ra2;
  endtask

  task automatic wr_a(input logic we, input logic [5:0] a,
                      input logic [31:0] d);
    b0.WE_A = we; b1.WE_A = we;
    b0.WA_A = a;  b1.WA_A = a;
    b0.WD_A = d;  b1.WD_A = d;
  endtask

  task automatic set_ra(input logic [5:0] a0, input logic [5:0] a1,
                        input logic [5:0] a2);
    b0.RA_0 = a0; b1.RA_0 = a0;
    b0.RA_1 = a1; b1.RA_1 = a1;
    b0.RA_2 = a2; b1.RA_2 = a2;
  endtask

  task automatic set_clr(input logic c);
    b0.CLR_REQ = c;
    b1.CLR_REQ = c;
  endtask

  vec_t idle;
  int   bad;

  initial begin
    idle = '{1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd0, 6'd0, 6'd0,
             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    //          weA wa    wdA           weB wb    wdB
    //          ra0 ra1 ra2 | u0 rd0..2 | u1 rd0..2
    vt[0]  = '{1, 3, 32'h12345678, 0, 0, 32'h0, 0, 3, 0,
               32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[1]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 3, 0,
               32'h0, 32'h12345678, 32'h0, 32'h0, 32'h12345678, 32'h0};
    vt[2]  = '{1, 10, 32'hAAAA0000, 1, 10, 32'h0000BBBB, 10, 0, 0,
               32'h0000BBBB, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[3]  = '{0, 0, 32'h0, 0, 0, 32'h0, 10, 3, 0,
               32'h0000BBBB, 32'h12345678, 32'h0,
               32'h0000BBBB, 32'h12345678, 32'h0};
    vt[4]  = '{1, 10, 32'h11111111, 1, 11, 32'h22222222, 10, 11, 0,
               32'h11111111, 32'h22222222, 32'h0,
               32'h0000BBBB, 32'h0, 32'h0};
    vt[5]  = '{0, 0, 32'h0, 0, 0, 32'h0, 10, 11, 3,
               32'h11111111, 32'h22222222, 32'h12345678,
               32'h11111111, 32'h22222222, 32'h12345678};
    vt[6]  = '{0, 0, 32'h0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h0, 32'h0, 32'h0};
    vt[7]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h0, 32'h0, 32'h0};
    vt[8]  = '{1, 1, 32'hCAFEF00D, 1, 13, 32'h13131313, 1, 13, 0,
               32'hCAFEF00D, 32'h13131313, 32'hFFFFFFFF,
               32'h0, 32'h0, 32'h0};
    vt[9]  = '{0, 0, 32'h0, 0, 0, 32'h0, 1, 13, 0,
               32'hCAFEF00D, 32'h13131313, 32'hFFFFFFFF,
               32'hCAFEF00D, 32'h13131313, 32'h0};
    vt[10] = '{1, 45, 32'h55555555, 0, 0, 32'h0, 45, 13, 0,
               32'h55555555, 32'h13131313, 32'hFFFFFFFF,
               32'h0, 32'h13131313, 32'h0};
    vt[11] = '{0, 0, 32'h0, 0, 0, 32'h0, 45, 13, 0,
               32'h55555555, 32'h13131313, 32'hFFFFFFFF,
               32'h0, 32'h13131313, 32'h0};
    vt[12] = '{1, 63, 32'h63636363, 1, 2, 32'h02020202, 63, 2, 1,
               32'h63636363, 32'h02020202, 32'hCAFEF00D,
               32'h0, 32'h0, 32'hCAFEF00D};
    vt[13] = '{0, 0, 32'h0, 0, 0, 32'h0, 63, 2, 1,
               32'h63636363, 32'h02020202, 32'hCAFEF00D,
               32'h0, 32'h02020202, 32'hCAFEF00D};

    drive(idle);
    set_clr(1'b0);
    rst = 1'b1;
    step();
    chk("rst u0 ready", 32'(b0.READY), 32'd0);
    chk("rst u1 ready", 32'(b1.READY), 32'd0);
    chk("rst u0 rd0", b0.RD_0, 32'h0);

    // Initial clear, with a write to 5 that must be ignored.
    rst = 1'b0;
    wr_a(1'b1, 6'd5, 32'hDEADBEEF);
    set_ra(6'd5, 6'd5, 6'd5);
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k == 30) wr_a(1'b0, 6'd0, 32'h0);
      if (k == 10) chk("clr u0 rd0 forced", b0.RD_0, 32'h0);
      if (k == 39) chk("clr u1 ready@39", 32'(b1.READY), 32'd0);
      if (k == 40) chk("clr u1 ready@40", 32'(b1.READY), 32'd1);
      if (k == 63) chk("clr u0 ready@63", 32'(b0.READY), 32'd0);
      if (k == 64) chk("clr u0 ready@64", 32'(b0.READY), 32'd1);
    end
    chk("clr u0 addr5", b0.RD_0, 32'h0);
    chk("clr u1 addr5", b1.RD_0, 32'h0);
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      set_ra(6'(a), 6'(a), 6'(a));
      #1;
      if (b0.RD_0 !== 32'h0 || b0.RD_2 !== 32'h0 ||
          b1.RD_1 !== 32'h0)
        bad++;
    end
    chk("clr all zero badcnt", 32'(bad), 32'd0);

    // Table of single-cycle vectors: pre-edge reads, then the edge.
    for (int i = 0; i < 14; i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d u0 rd0", i), b0.RD_0, vt[i].e00);
      chk($sformatf("v%0d u0 rd1", i), b0.RD_1, vt[i].e01);
      chk($sformatf("v%0d u0 rd2", i), b0.RD_2, vt[i].e02);
      chk($sformatf("v%0d u1 rd0", i), b1.RD_0, vt[i].e10);
      chk($sformatf("v%0d u1 rd1", i), b1.RD_1, vt[i].e11);
      chk($sformatf("v%0d u1 rd2", i), b1.RD_2, vt[i].e12);
      step();
    end
    drive(idle);

    // Fill every entry with its index, then clear via CLR_REQ.
    for (int a = 0; a < 64; a++) begin
      wr_a(1'b1, 6'(a), 32'(a));
      step();
    end
    wr_a(1'b0, 6'd0, 32'h0);
    set_ra(6'd7, 6'd39, 6'd45);
    #1;
    chk("fill u0 e7", b0.RD_0, 32'd7);
    chk("fill u0 e45", b0.RD_2, 32'd45);
    chk("fill u1 e39", b1.RD_1, 32'd39);
    chk("fill u1 e45 oor", b1.RD_2, 32'h0);
    set_ra(6'd0, 6'd63, 6'd45);
    #1;
    chk("fill u1 e0 zero", b1.RD_0, 32'h0);
    chk("fill u0 e0", b0.RD_0, 32'h0);
    chk("fill u0 e63", b0.RD_1, 32'd63);

    set_clr(1'b1);
    wr_a(1'b1, 6'd7, 32'h77777777);
    set_ra(6'd7, 6'd7, 6'd7);
    #1;
    chk("clrreq no bypass u0", b0.RD_0, 32'd7);
    chk("clrreq u1 rd0", b1.RD_0, 32'd7);
    step();
    set_clr(1'b0);
    wr_a(1'b0, 6'd0, 32'h0);
    chk("clrreq u0 ready drop", 32'(b0.READY), 32'd0);
    chk("clrreq u1 ready drop", 32'(b1.READY), 32'd0);
    chk("clrreq u0 rd forced", b0.RD_0, 32'h0);
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k == 39) chk("req u1 ready@39", 32'(b1.READY), 32'd0);
      if (k == 40) chk("req u1 ready@40", 32'(b1.READY), 32'd1);
      if (k == 63) chk("req u0 ready@63", 32'(b0.READY), 32'd0);
      if (k == 64) chk("req u0 ready@64", 32'(b0.READY), 32'd1);
    end
    chk("req u0 e7 zero", b0.RD_0, 32'h0);
    chk("req u1 e7 zero", b1.RD_0, 32'h0);
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      set_ra(6'(a), 6'(a), 6'(a));
      #1;
      if (b0.RD_1 !== 32'h0 || b1.RD_2 !== 32'h0)
        bad++;
    end
    chk("req all zero badcnt", 32'(bad), 32'd0);

    // RST mid-clear restarts the count.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 39) chk("rerst u1 ready@39", 32'(b1.READY), 32'd0);
      if (k == 40) chk("rerst u1 ready@40", 32'(b1.READY), 32'd1);
      if (k == 40) chk("rerst u0 ready@40", 32'(b0.READY), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
